// File: rtl/cache_controller_pkg.sv
// Shared types, geometry constants and field helpers for the two-way read cache.
package cache_controller_pkg;

    localparam int unsigned CACHE_ADDR_WIDTH = 32;
    localparam int unsigned CACHE_INDEX_BITS = 6;
    localparam int unsigned CACHE_TAG_BITS   = CACHE_ADDR_WIDTH - CACHE_INDEX_BITS - 3;
    localparam int unsigned LINE_BITS        = 64;
    localparam int unsigned WORD_BITS        = 32;
    localparam int unsigned WORD_SEL_BIT     = 2;
    localparam int unsigned INDEX_LSB        = 3;

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR_THRU
    } state_t;

    // Word at address[2]=0 lives in the upper half of the line.
    function automatic logic [WORD_BITS-1:0] select_word(
        input logic [LINE_BITS-1:0] line,
        input logic                 word_sel
    );
        return word_sel ? line[WORD_BITS-1:0] : line[LINE_BITS-1:WORD_BITS];
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// Memory-stage request bus plus the sram_controller request bus seen by the cache.
interface cache_controller_if
    import cache_controller_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = CACHE_ADDR_WIDTH
);
    logic                  mem_read_en;
    logic                  mem_write_en;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [WORD_BITS-1:0]  mem_write_data;
    logic [WORD_BITS-1:0]  mem_read_data;
    logic                  mem_ready;
    logic                  sram_read_en;
    logic                  sram_write_en;
    logic [ADDR_WIDTH-1:0] sram_address;
    logic [WORD_BITS-1:0]  sram_write_data;
    logic [LINE_BITS-1:0]  sram_read_data;
    logic                  sram_ready;

    modport slave (
        input  mem_read_en, mem_write_en, mem_address, mem_write_data,
        input  sram_read_data, sram_ready,
        output mem_read_data, mem_ready,
        output sram_read_en, sram_write_en, sram_address, sram_write_data
    );

    modport master (
        output mem_read_en, mem_write_en, mem_address, mem_write_data,
        output sram_read_data, sram_ready,
        input  mem_read_data, mem_ready,
        input  sram_read_en, sram_write_en, sram_address, sram_write_data
    );
endinterface

// File: rtl/cache_way.sv
// One way of the cache: valid/tag/data arrays with async read, line fill and word write.
module cache_way
    import cache_controller_pkg::*;
#(
    parameter int unsigned INDEX_BITS = CACHE_INDEX_BITS,
    parameter int unsigned TAG_BITS   = CACHE_TAG_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] index,
    input  logic [TAG_BITS-1:0]   tag,
    input  logic                  fill_en,
    input  logic [LINE_BITS-1:0]  fill_line,
    input  logic                  word_en,
    input  logic                  word_sel,
    input  logic [WORD_BITS-1:0]  word_data,
    output logic                  hit,
    output logic [LINE_BITS-1:0]  line
);
    localparam int unsigned SETS = 1 << INDEX_BITS;

    logic [SETS-1:0]      valid;
    logic [TAG_BITS-1:0]  tags [SETS];
    logic [LINE_BITS-1:0] data [SETS];

    assign hit  = valid[index] && (tags[index] == tag);
    assign line = data[index];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[index] <= 1'b1;
        end
    end

    // Tag and data arrays are deliberately not reset; valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[index] <= tag;
            data[index] <= fill_line;
        end else if (word_en) begin
            if (word_sel) begin
                data[index][WORD_BITS-1:0] <= word_data;
            end else begin
                data[index][LINE_BITS-1:WORD_BITS] <= word_data;
            end
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate read cache in front of
// sram_controller; read hits complete with zero wait states.
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = CACHE_ADDR_WIDTH,
    parameter int unsigned INDEX_BITS = CACHE_INDEX_BITS,
    parameter int unsigned TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 3
) (
    input logic               clk,
    input logic               rst,
    cache_controller_if.slave bus
);
    localparam int unsigned SETS = 1 << INDEX_BITS;

    state_t state;
    state_t state_next;

    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  word_sel;
    logic                  read_req;
    logic                  write_req;

    logic                  hit0;
    logic                  hit1;
    logic                  hit;
    logic [LINE_BITS-1:0]  line0;
    logic [LINE_BITS-1:0]  line1;
    logic [LINE_BITS-1:0]  hit_line;

    logic [SETS-1:0]       lru;
    logic                  victim;
    logic                  fill_done;
    logic                  write_done;
    logic                  read_hit;

    assign index     = bus.mem_address[INDEX_BITS+INDEX_LSB-1:INDEX_LSB];
    assign tag       = bus.mem_address[ADDR_WIDTH-1:INDEX_BITS+INDEX_LSB];
    assign word_sel  = bus.mem_address[WORD_SEL_BIT];
    assign write_req = bus.mem_write_en;
    assign read_req  = bus.mem_read_en && !bus.mem_write_en;

    assign hit      = hit0 || hit1;
    assign hit_line = hit1 ? line1 : line0;
    assign victim   = lru[index];

    // Array updates are masked by rst so an interrupted fill or store leaves no trace.
    assign fill_done  = (state == RD_MISS) && bus.sram_ready && !rst;
    assign write_done = (state == WR_THRU) && bus.sram_ready && !rst;
    assign read_hit   = (state == IDLE) && read_req && hit && !rst;

    assign bus.sram_address    = bus.mem_address;
    assign bus.sram_write_data = bus.mem_write_data;

    cache_way #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_way0 (
        .clk       (clk),
        .rst       (rst),
        .index     (index),
        .tag       (tag),
        .fill_en   (fill_done && !victim),
        .fill_line (bus.sram_read_data),
        .word_en   (write_done && hit0),
        .word_sel  (word_sel),
        .word_data (bus.mem_write_data),
        .hit       (hit0),
        .line      (line0)
    );

    cache_way #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_way1 (
        .clk       (clk),
        .rst       (rst),
        .index     (index),
        .tag       (tag),
        .fill_en   (fill_done && victim),
        .fill_line (bus.sram_read_data),
        .word_en   (write_done && hit1),
        .word_sel  (word_sel),
        .word_data (bus.mem_write_data),
        .hit       (hit1),
        .line      (line1)
    );

    // lru names the way to replace next, so it points away from the way just used.
    always_ff @(posedge clk) begin
        if (rst) begin
            lru <= '0;
        end else if (fill_done) begin
            lru[index] <= !victim;
        end else if (read_hit || (write_done && hit)) begin
            lru[index] <= !hit1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (write_req) begin
                    state_next = WR_THRU;
                end else if (read_req && !hit) begin
                    state_next = RD_MISS;
                end
            end
            RD_MISS: begin
                if (bus.sram_ready) begin
                    state_next = IDLE;
                end
            end
            WR_THRU: begin
                if (bus.sram_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.sram_read_en  = 1'b0;
        bus.sram_write_en = 1'b0;
        bus.mem_ready     = 1'b1;
        bus.mem_read_data = '0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (write_req) begin
                        bus.mem_ready = 1'b0;
                    end else if (read_req) begin
                        if (hit) begin
                            bus.mem_read_data = select_word(hit_line, word_sel);
                        end else begin
                            bus.mem_ready = 1'b0;
                        end
                    end
                end
                RD_MISS: begin
                    bus.sram_read_en = 1'b1;
                    bus.mem_ready    = bus.sram_ready;
                    if (bus.sram_ready) begin
                        bus.mem_read_data = select_word(bus.sram_read_data, word_sel);
                    end
                end
                WR_THRU: begin
                    bus.sram_write_en = 1'b1;
                    bus.mem_ready     = bus.sram_ready;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller with a behavioural sram_controller and backing store.
module tb_cache_controller;
    import cache_controller_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cache_controller_if #(.ADDR_WIDTH(32)) bus ();

    cache_controller #(
        .ADDR_WIDTH (32),
        .INDEX_BITS (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Backing store keyed by line address; untouched lines read as an address-derived pattern.
    logic [63:0] mem_model [logic [28:0]];
    int unsigned sram_cnt = 0;
    logic [63:0] sram_line_q = '0;

    function automatic logic [63:0] line_at(input logic [31:0] addr);
        logic [28:0] k;
        logic [31:0] la;
        k  = addr[31:3];
        la = {addr[31:3], 3'b000};
        if (mem_model.exists(k)) return mem_model[k];
        return {la ^ 32'h5A5A_0000, ~la};
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        logic [63:0] l;
        l = line_at(addr);
        return addr[2] ? l[31:0] : l[63:32];
    endfunction

    // sram_controller: ready low for 5 cycles of an asserted request, then one completion cycle.
    always @(posedge clk) begin
        if (bus.sram_read_en || bus.sram_write_en) sram_cnt <= sram_cnt + 1;
        else sram_cnt <= 0;
        sram_line_q <= line_at(bus.sram_address);
    end
    assign bus.sram_ready     = !(bus.sram_read_en || bus.sram_write_en) || (sram_cnt == 5);
    assign bus.sram_read_data = sram_line_q;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] addr;
        logic [31:0] data;
        bit          is_wr;
        bit          miss;
        int unsigned waits;
    } exp_t;

    exp_t sb[$];

    task automatic finish_txn();
        exp_t        e;
        int unsigned waits = 0;
        bit          saw_rd = 0;
        bit          saw_wr = 0;
        bit          done = 0;
        logic [63:0] l;
        logic [31:0] got_data = '0;
        logic [31:0] got_wdata = '0;
        logic [31:0] got_addr = '0;
        e = sb.pop_front();
        while (!done && waits <= 20) begin
            @(negedge clk);
            if (bus.sram_read_en) saw_rd = 1;
            if (bus.sram_write_en) saw_wr = 1;
            if (bus.mem_ready) begin
                done      = 1;
                got_data  = bus.mem_read_data;
                got_wdata = bus.sram_write_data;
                got_addr  = bus.sram_address;
            end else begin
                waits++;
            end
        end
        check({e.tag, " done"}, 64'(done), 64'd1);
        if (done) begin
            check({e.tag, " wait cycles"}, 64'(waits), 64'(e.waits));
            check({e.tag, " sram_read_en seen"}, 64'(saw_rd), 64'(!e.is_wr && e.miss));
            check({e.tag, " sram_write_en seen"}, 64'(saw_wr), 64'(e.is_wr));
            if (e.is_wr) begin
                check({e.tag, " sram_write_data"}, 64'(got_wdata), 64'(e.data));
                check({e.tag, " sram_address"}, 64'(got_addr), 64'(e.addr));
                l = line_at(e.addr);
                if (e.addr[2]) l[31:0] = e.data;
                else l[63:32] = e.data;
                mem_model[e.addr[31:3]] = l;
            end else begin
                check({e.tag, " read data"}, 64'(got_data), 64'(e.data));
            end
        end
        @(posedge clk);
        #1;
        bus.mem_read_en  = 1'b0;
        bus.mem_write_en = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input bit miss);
        exp_t e;
        e.tag   = tag;
        e.addr  = addr;
        e.data  = word_at(addr);
        e.is_wr = 0;
        e.miss  = miss;
        e.waits = miss ? 6 : 0;
        sb.push_back(e);
        bus.mem_address  = addr;
        bus.mem_read_en  = 1'b1;
        bus.mem_write_en = 1'b0;
        finish_txn();
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input bit with_read);
        exp_t e;
        e.tag   = tag;
        e.addr  = addr;
        e.data  = data;
        e.is_wr = 1;
        e.miss  = 0;
        e.waits = 6;
        sb.push_back(e);
        bus.mem_address    = addr;
        bus.mem_write_data = data;
        bus.mem_read_en    = with_read;
        bus.mem_write_en   = 1'b1;
        finish_txn();
    endtask

    task automatic idle_outputs(input string tag);
        check({tag, " mem_ready"}, 64'(bus.mem_ready), 64'd1);
        check({tag, " sram_read_en"}, 64'(bus.sram_read_en), 64'd0);
        check({tag, " sram_write_en"}, 64'(bus.sram_write_en), 64'd0);
        check({tag, " mem_read_data"}, 64'(bus.mem_read_data), 64'd0);
    endtask

    logic [31:0] a;
    int unsigned rm_cycles;

    initial begin
        a = 32'h0000_0400;
        mem_model[a[31:3]] = 64'hAAAABBBB_CCCCDDDD;
        rst                = 1'b1;
        bus.mem_read_en    = 1'b0;
        bus.mem_write_en   = 1'b0;
        bus.mem_address    = '0;
        bus.mem_write_data = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        idle_outputs("in reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        idle_outputs("idle after reset");
        @(posedge clk);
        #1;

        do_read("t1 miss 0x400", 32'h400, 1);
        do_read("t1 hit 0x404", 32'h404, 0);

        do_read("t2 miss 0x600", 32'h600, 1);
        do_read("t2 hit 0x400", 32'h400, 0);
        do_read("t2 miss 0x800", 32'h800, 1);
        do_read("t2 hit 0x400 after", 32'h400, 0);
        do_read("t2 miss 0x600 evicted", 32'h600, 1);

        do_write("t3 write hit 0x404", 32'h404, 32'h1234_5678, 0);
        do_read("t3 hit 0x404", 32'h404, 0);
        do_read("t3 hit 0x400", 32'h400, 0);

        do_write("t4 write miss 0x1000", 32'h1000, 32'hDEAD_BEEF, 0);
        do_read("t4 miss 0x1000", 32'h1000, 1);
        do_read("t4 hit 0x1000", 32'h1000, 0);

        bus.mem_address = 32'h2000;
        bus.mem_read_en = 1'b1;
        rm_cycles = 0;
        for (int c = 0; c < 20 && rm_cycles < 2; c++) begin
            @(negedge clk);
            if (bus.sram_read_en) rm_cycles++;
            @(posedge clk);
            #1;
        end
        check("t5 rd_miss cycles before reset", 64'(rm_cycles), 64'd2);
        rst             = 1'b1;
        bus.mem_read_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5 sram_read_en after reset", 64'(bus.sram_read_en), 64'd0);
        check("t5 mem_ready after reset", 64'(bus.mem_ready), 64'd1);
        @(posedge clk);
        #1;
        do_read("t5 miss 0x400", 32'h400, 1);
        do_read("t5 miss 0x2000", 32'h2000, 1);

        do_write("t6 both hit 0x400", 32'h400, 32'h0BAD_F00D, 1);
        do_read("t6 hit 0x400", 32'h400, 0);
        do_write("t6 both miss 0x3000", 32'h3000, 32'hCAFE_0001, 1);
        do_read("t6 miss 0x3000", 32'h3000, 1);

        check("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
